// File: rtl/decode_regfile_if.sv
// rtl/decode_regfile_if.sv - decode/writeback port bundle for the register file and scoreboard
interface decode_regfile_if;
    // writeback stage
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    // decode stage reads
    logic [4:0]  RS1D;
    logic [4:0]  RS2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    // decode stage issue
    logic        IssueValidD;
    logic        RegWriteD;
    logic [4:0]  RDD;
    logic        StallD;
    logic        ScbErr;

    modport master (
        output RegWriteW, RDW, ResultW,
        output RS1D, RS2D,
        output IssueValidD, RegWriteD, RDD,
        input  RD1D, RD2D, StallD, ScbErr
    );

    modport slave (
        input  RegWriteW, RDW, ResultW,
        input  RS1D, RS2D,
        input  IssueValidD, RegWriteD, RDD,
        output RD1D, RD2D, StallD, ScbErr
    );
endinterface

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 31x32 register file with 2-bit pending-write scoreboard; optional write-through bypass under WB_BYPASS_EN
module decode_regfile (
    input  logic             clk,
    input  logic             rst,
    decode_regfile_if.slave  rf
);

    logic [31:0] regs [32];
    logic [1:0]  pc   [32];
    logic        scb_err;

    logic        wb_en;
    logic [31:0] rd1_stored;
    logic [31:0] rd2_stored;
    logic        byp1;
    logic        byp2;
    logic        haz1;
    logic        haz2;
    logic        dest_full;
    logic        stall;
    logic        inc_en;
    logic [31:0] inc_vec;
    logic [31:0] wb_vec;
    logic        spurious;

    // Writeback qualifier shared by the array, scoreboard and bypass
    assign wb_en = rf.RegWriteW && (rf.RDW != 5'd0);

    // Stored read values; x0 is hard-wired to zero
    always_comb begin
        rd1_stored = 32'd0;
        rd2_stored = 32'd0;
        if (rf.RS1D != 5'd0) rd1_stored = regs[rf.RS1D];
        if (rf.RS2D != 5'd0) rd2_stored = regs[rf.RS2D];
    end

`ifdef WB_BYPASS_EN
    // Same-cycle writeback forwards ResultW and clears a hazard on the last pending write
    always_comb begin
        byp1 = rst && wb_en && (rf.RDW == rf.RS1D);
        byp2 = rst && wb_en && (rf.RDW == rf.RS2D);
        rf.RD1D = byp1 ? rf.ResultW : rd1_stored;
        rf.RD2D = byp2 ? rf.ResultW : rd2_stored;
        haz1 = (rf.RS1D != 5'd0) && (pc[rf.RS1D] != 2'd0)
               && !(byp1 && (pc[rf.RS1D] == 2'd1));
        haz2 = (rf.RS2D != 5'd0) && (pc[rf.RS2D] != 2'd0)
               && !(byp2 && (pc[rf.RS2D] == 2'd1));
    end
`else
    // Reads return stored values only; a hazard holds until the write has landed
    always_comb begin
        byp1 = 1'b0;
        byp2 = 1'b0;
        rf.RD1D = rd1_stored;
        rf.RD2D = rd2_stored;
        haz1 = (rf.RS1D != 5'd0) && (pc[rf.RS1D] != 2'd0);
        haz2 = (rf.RS2D != 5'd0) && (pc[rf.RS2D] != 2'd0);
    end
`endif

    // Stall decision, issue qualification and per-register scoreboard events
    always_comb begin
        dest_full = (pc[rf.RDD] == 2'd3) && !(wb_en && (rf.RDW == rf.RDD));
        stall     = rf.IssueValidD
                    && (haz1 || haz2
                        || (rf.RegWriteD && (rf.RDD != 5'd0) && dest_full));
        inc_en    = rf.IssueValidD && !stall && rf.RegWriteD && (rf.RDD != 5'd0);
        inc_vec   = inc_en ? (32'd1 << rf.RDD) : 32'd0;
        wb_vec    = wb_en ? (32'd1 << rf.RDW) : 32'd0;
        spurious  = wb_en && (pc[rf.RDW] == 2'd0);
    end

    assign rf.StallD = stall;
    assign rf.ScbErr = scb_err;

    // Register array write port; stalls never touch stored data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wb_en) begin
            regs[rf.RDW] <= rf.ResultW;
        end
    end

    // Pending counts: issue increments, writeback decrements, both together cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) pc[i] <= 2'd0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc_vec[r] && !wb_vec[r]) begin
                    pc[r] <= pc[r] + 2'd1;
                end else if (wb_vec[r] && !inc_vec[r] && (pc[r] != 2'd0)) begin
                    pc[r] <= pc[r] - 2'd1;
                end
            end
        end
    end

    // Sticky flag for a writeback that had no matching issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scb_err <= 1'b0;
        end else if (spurious) begin
            scb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_regfile.sv
// tb/tb_decode_regfile.sv - table-driven scoreboard bench for decode_regfile
module tb_decode_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    decode_regfile_if bus ();

    decode_regfile dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rw_w;
        logic [4:0]  rdw;
        logic [31:0] res_w;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        iv;
        logic        rw_d;
        logic [4:0]  rdd;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_stall;
        logic        e_scb;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks;
    int   n_fail;

    function automatic vec_t mk(string name, logic rw_w, logic [4:0] rdw, logic [31:0] res_w,
                                logic [4:0] rs1, logic [4:0] rs2, logic iv, logic rw_d,
                                logic [4:0] rdd, logic [31:0] e_rd1, logic [31:0] e_rd2,
                                logic e_stall, logic e_scb);
        vec_t v;
        v.name = name; v.rw_w = rw_w; v.rdw = rdw; v.res_w = res_w;
        v.rs1 = rs1; v.rs2 = rs2; v.iv = iv; v.rw_d = rw_d; v.rdd = rdd;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_stall = e_stall; v.e_scb = e_scb;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.RegWriteW   = v.rw_w;
        bus.RDW         = v.rdw;
        bus.ResultW     = v.res_w;
        bus.RS1D        = v.rs1;
        bus.RS2D        = v.rs2;
        bus.IssueValidD = v.iv;
        bus.RegWriteD   = v.rw_d;
        bus.RDD         = v.rdd;
        exp_q.push_back(v);
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = exp_q.pop_front();
        chk({e.name, "_rd1"},   bus.RD1D,   e.e_rd1);
        chk({e.name, "_rd2"},   bus.RD2D,   e.e_rd2);
        chk({e.name, "_stall"}, {31'd0, bus.StallD}, {31'd0, e.e_stall});
        chk({e.name, "_scb"},   {31'd0, bus.ScbErr}, {31'd0, e.e_scb});
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        n_checks = 0;
        n_fail = 0;

        //           name    rw rdw res           rs1 rs2 iv rwd rdd  rd1                          rd2      st scb
        vecs.push_back(mk("iss3",  0, 0, 0,            0, 0, 1, 1, 3,  0,                           0,       0, 0));
        vecs.push_back(mk("wb3",   1, 3, 32'h0000000A, 3, 0, 0, 0, 0,  BYP ? 32'h0000000A : 32'h0, 0,       0, 0));
        vecs.push_back(mk("wbx0",  1, 0, 32'hFFFFFFFF, 3, 0, 0, 0, 0,  32'h0000000A,                0,       0, 0));
        vecs.push_back(mk("iss7",  0, 0, 0,            3, 3, 1, 1, 7,  32'h0000000A,       32'h0000000A,     0, 0));
        vecs.push_back(mk("raw7",  0, 0, 0,            7, 0, 1, 0, 0,  0,                           0,       1, 0));
        vecs.push_back(mk("wb7",   1, 7, 32'h0000000B, 7, 0, 1, 0, 0,  BYP ? 32'h0000000B : 32'h0, 0,       !BYP, 0));
        vecs.push_back(mk("post7", 0, 0, 0,            7, 0, 1, 0, 0,  32'h0000000B,                0,       0, 0));
        vecs.push_back(mk("s9a",   0, 0, 0,            0, 0, 1, 1, 9,  0,                           0,       0, 0));
        vecs.push_back(mk("s9b",   0, 0, 0,            0, 0, 1, 1, 9,  0,                           0,       0, 0));
        vecs.push_back(mk("s9c",   0, 0, 0,            0, 0, 1, 1, 9,  0,                           0,       0, 0));
        vecs.push_back(mk("s9full",0, 0, 0,            0, 0, 1, 1, 9,  0,                           0,       1, 0));
        vecs.push_back(mk("s9wb",  1, 9, 32'h00000099, 0, 0, 1, 1, 9,  0,                           0,       0, 0));
        vecs.push_back(mk("s9hold",0, 0, 0,            0, 0, 1, 1, 9,  0,                           0,       1, 0));
        vecs.push_back(mk("d9a",   1, 9, 32'h00000091, 0, 0, 0, 0, 0,  0,                           0,       0, 0));
        vecs.push_back(mk("d9b",   1, 9, 32'h00000092, 0, 0, 0, 0, 0,  0,                           0,       0, 0));
        vecs.push_back(mk("d9c",   1, 9, 32'h00000093, 0, 0, 0, 0, 0,  0,                           0,       0, 0));
        vecs.push_back(mk("rd9",   0, 0, 0,            9, 0, 1, 0, 0,  32'h00000093,                0,       0, 0));
        vecs.push_back(mk("spur12",1, 12,32'h0000000C, 12,0, 0, 0, 0,  BYP ? 32'h0000000C : 32'h0, 0,       0, 0));
        vecs.push_back(mk("rd12",  0, 0, 0,            12,0, 0, 0, 0,  32'h0000000C,                0,       0, 1));
        vecs.push_back(mk("iss4a", 0, 0, 0,            0, 0, 1, 1, 4,  0,                           0,       0, 1));
        vecs.push_back(mk("iss4b", 0, 0, 0,            0, 0, 1, 1, 4,  0,                           0,       0, 1));

        // Reset-state read
        drive(mk("rst", 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        #3;
        check_out();
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check_out();
        end

        // x4 has two pending writes: a reader must stall
        @(posedge clk);
        #1;
        drive(mk("pre_rst", 0, 0, 0, 4, 3, 1, 0, 0, 0, 32'h0000000A, 1, 1));
        #2;
        check_out();

        // Asynchronous reset mid-cycle drops counts, data and the error flag at once
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, bus.StallD}, 32'd0);
        chk("mid_rst_rd2",   bus.RD2D, 32'd0);
        chk("mid_rst_scb",   {31'd0, bus.ScbErr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First edge after release is a normal cycle: a spurious write to x5 lands
        bus.RegWriteW = 1'b1;
        bus.RDW       = 5'd5;
        bus.ResultW   = 32'h00000055;
        #1;
        chk("post_rst_stall", {31'd0, bus.StallD}, 32'd0);
        chk("post_rst_rd1",   bus.RD1D, 32'd0);
        @(posedge clk);
        #1;
        bus.RegWriteW = 1'b0;
        bus.RS1D      = 5'd5;
        #1;
        chk("post_rst_wr5",  bus.RD1D, 32'h00000055);
        chk("post_rst_scb",  {31'd0, bus.ScbErr}, 32'd1);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
